// File: rtl/cam_pixel_fifo_writer.sv
// Camera capture front end: assembles RGB565 pixels from the byte stream, tags
// start-of-frame, and pushes 17-bit words into an embedded dual-clock FIFO.
module cam_pixel_fifo_writer #(
  parameter int LINE_PIXELS      = 640,
  parameter int FRAME_LINES      = 480,
  parameter int FIFO_DEPTH_WIDTH = 10
) (
  input  logic                        clk_w,
  input  logic                        rst_n,
  input  logic                        clk_r,
  input  logic                        cam_pclk_en,
  input  logic                        cam_vsync,
  input  logic                        cam_href,
  input  logic [7:0]                  cam_data,
  input  logic                        rd_fifo,
  output logic [16:0]                 dout,
  output logic [FIFO_DEPTH_WIDTH-1:0] data_count_r,
  output logic                        overflow,
  output logic [7:0]                  frame_count,
  output logic [1:0]                  dbg_state
);

  localparam int AW = FIFO_DEPTH_WIDTH;
  localparam int PW = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam int LW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES + 1) : 1;
  localparam logic [PW-1:0] PIX_LAST   = PW'(LINE_PIXELS - 1);
  localparam logic [LW-1:0] LINES_LAST = LW'(FRAME_LINES - 1);

  typedef enum logic [1:0] {
    WAIT_VS  = 2'd0,
    WAIT_ACT = 2'd1,
    ACTIVE   = 2'd2,
    DROP     = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          byte_phase_q, byte_phase_d;
  logic [7:0]    hi_byte_q, hi_byte_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic          line_full_q, line_full_d;
  logic [LW-1:0] line_cnt_q, line_cnt_d;
  logic          href_prev_q, href_prev_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    frame_count_q, frame_count_d;
  logic          write_q, write_d;
  logic [16:0]   data_write_q, data_write_d;
  logic          sof;
  logic          full_w;

  assign sof = (pix_cnt_q == '0) && (line_cnt_q == '0);

  // Capture control. Everything except the DROP exit is gated by the pixel strobe.
  always_comb begin
    state_d       = state_q;
    byte_phase_d  = byte_phase_q;
    hi_byte_d     = hi_byte_q;
    pix_cnt_d     = pix_cnt_q;
    line_full_d   = line_full_q;
    line_cnt_d    = line_cnt_q;
    href_prev_d   = href_prev_q;
    overflow_d    = overflow_q;
    frame_count_d = frame_count_q;
    write_d       = 1'b0;
    data_write_d  = data_write_q;
    if (state_q == DROP) begin
      state_d = WAIT_VS;
    end else if (cam_pclk_en) begin
      href_prev_d = cam_href;
      case (state_q)
        WAIT_VS: begin
          if (cam_vsync) state_d = WAIT_ACT;
        end
        WAIT_ACT: begin
          if (!cam_vsync) begin
            state_d      = ACTIVE;
            byte_phase_d = 1'b0;
            pix_cnt_d    = '0;
            line_full_d  = 1'b0;
            line_cnt_d   = '0;
          end
        end
        ACTIVE: begin
          if (cam_vsync) begin
            frame_count_d = frame_count_q + 8'd1;
            state_d       = WAIT_ACT;
          end else if (cam_href) begin
            if (!byte_phase_q) begin
              hi_byte_d    = cam_data;
              byte_phase_d = 1'b1;
            end else begin
              byte_phase_d = 1'b0;
              if (!line_full_q) begin
                if (full_w) begin
                  overflow_d = 1'b1;
                  state_d    = DROP;
                end else begin
                  write_d      = 1'b1;
                  data_write_d = {sof, hi_byte_q, cam_data};
                  if (pix_cnt_q == PIX_LAST) line_full_d = 1'b1;
                  else pix_cnt_d = pix_cnt_q + PW'(1);
                end
              end
            end
          end else if (href_prev_q) begin
            byte_phase_d = 1'b0;
            pix_cnt_d    = '0;
            line_full_d  = 1'b0;
            line_cnt_d   = line_cnt_q + LW'(1);
            if (line_cnt_q == LINES_LAST) begin
              frame_count_d = frame_count_q + 8'd1;
              state_d       = WAIT_VS;
            end
          end
        end
        default: state_d = WAIT_VS;
      endcase
    end
  end

  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_VS;
      byte_phase_q  <= 1'b0;
      hi_byte_q     <= 8'd0;
      pix_cnt_q     <= '0;
      line_full_q   <= 1'b0;
      line_cnt_q    <= '0;
      href_prev_q   <= 1'b0;
      overflow_q    <= 1'b0;
      frame_count_q <= 8'd0;
      write_q       <= 1'b0;
      data_write_q  <= 17'd0;
    end else begin
      state_q       <= state_d;
      byte_phase_q  <= byte_phase_d;
      hi_byte_q     <= hi_byte_d;
      pix_cnt_q     <= pix_cnt_d;
      line_full_q   <= line_full_d;
      line_cnt_q    <= line_cnt_d;
      href_prev_q   <= href_prev_d;
      overflow_q    <= overflow_d;
      frame_count_q <= frame_count_d;
      write_q       <= write_d;
      data_write_q  <= data_write_d;
    end
  end

  assign overflow    = overflow_q;
  assign frame_count = frame_count_q;
  assign dbg_state   = state_q;

  // Dual-clock FIFO: binary pointers one bit wider than the address, Gray copies
  // cross domains through two-flop synchronisers.
  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [16:0] mem [2**AW];
  logic [AW:0] wbin_q, wbin_d, wgray_q, wgray_d;
  logic [AW:0] rgray_s1_q, rgray_s2_q;
  logic [AW:0] rbin_q, rbin_d, rgray_q, rgray_d;
  logic [AW:0] wgray_s1_q, wgray_s2_q;
  logic [AW:0] fill_r;
  logic [16:0] dout_q, dout_d;
  logic        wr_ok, rd_ok, empty_r;

  assign full_w = (wgray_q == {~rgray_s2_q[AW:AW-1], rgray_s2_q[AW-2:0]});
  assign wr_ok  = write_q && !full_w;

  always_comb begin
    wbin_d  = wr_ok ? wbin_q + (AW+1)'(1) : wbin_q;
    wgray_d = wbin_d ^ (wbin_d >> 1);
  end

  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q     <= '0;
      wgray_q    <= '0;
      rgray_s1_q <= '0;
      rgray_s2_q <= '0;
    end else begin
      wbin_q     <= wbin_d;
      wgray_q    <= wgray_d;
      rgray_s1_q <= rgray_q;
      rgray_s2_q <= rgray_s1_q;
    end
  end

  always_ff @(posedge clk_w) begin
    if (wr_ok) mem[wbin_q[AW-1:0]] <= data_write_q;
  end

  // rd_fifo is a plain strobe: the word is popped on the clk_r edge where it is
  // high and appears on dout after that edge; a strobe while empty is ignored.
  assign empty_r = (rgray_q == wgray_s2_q);
  assign rd_ok   = rd_fifo && !empty_r;

  always_comb begin
    rbin_d  = rd_ok ? rbin_q + (AW+1)'(1) : rbin_q;
    rgray_d = rbin_d ^ (rbin_d >> 1);
    dout_d  = rd_ok ? mem[rbin_q[AW-1:0]] : dout_q;
  end

  always_ff @(posedge clk_r or negedge rst_n) begin
    if (!rst_n) begin
      rbin_q     <= '0;
      rgray_q    <= '0;
      wgray_s1_q <= '0;
      wgray_s2_q <= '0;
      dout_q     <= 17'd0;
    end else begin
      rbin_q     <= rbin_d;
      rgray_q    <= rgray_d;
      wgray_s1_q <= wgray_q;
      wgray_s2_q <= wgray_s1_q;
      dout_q     <= dout_d;
    end
  end

  // A completely full FIFO reports the largest count so the reader never stalls on it.
  assign fill_r       = gray2bin(wgray_s2_q) - rbin_q;
  assign data_count_r = fill_r[AW] ? {AW{1'b1}} : fill_r[AW-1:0];
  assign dout         = dout_q;

endmodule

// File: tb/tb_cam_pixel_fifo_writer.sv
// Randomised bench for cam_pixel_fifo_writer: a small-frame instance for the
// functional cases and a long-line instance for the overflow case.
module tb_cam_pixel_fifo_writer;

  localparam int DEPTH = 1024;
  localparam int LP_A = 4, FL_A = 2;
  localparam int LP_B = 1100, FL_B = 1;

  logic clk_w = 1'b0, clk_r = 1'b0, rst_n = 1'b0;
  logic pclk_en = 1'b0, vs = 1'b0, hr = 1'b0;
  logic [7:0] dat = 8'd0;
  int sel = 0;
  logic en_a, en_b;
  logic rd_a = 1'b0, rd_b = 1'b0;
  logic [16:0] dout_a, dout_b;
  logic [9:0] cnt_a, cnt_b;
  logic ovf_a, ovf_b;
  logic [7:0] fc_a, fc_b;
  logic [1:0] st_a, st_b;

  assign en_a = pclk_en && (sel == 0);
  assign en_b = pclk_en && (sel == 1);

  always #5 clk_w = ~clk_w;
  always #7 clk_r = ~clk_r;

  cam_pixel_fifo_writer #(.LINE_PIXELS(LP_A), .FRAME_LINES(FL_A), .FIFO_DEPTH_WIDTH(10)) dut_a (
    .clk_w(clk_w), .rst_n(rst_n), .clk_r(clk_r), .cam_pclk_en(en_a), .cam_vsync(vs),
    .cam_href(hr), .cam_data(dat), .rd_fifo(rd_a), .dout(dout_a), .data_count_r(cnt_a),
    .overflow(ovf_a), .frame_count(fc_a), .dbg_state(st_a)
  );

  cam_pixel_fifo_writer #(.LINE_PIXELS(LP_B), .FRAME_LINES(FL_B), .FIFO_DEPTH_WIDTH(10)) dut_b (
    .clk_w(clk_w), .rst_n(rst_n), .clk_r(clk_r), .cam_pclk_en(en_b), .cam_vsync(vs),
    .cam_href(hr), .cam_data(dat), .rd_fifo(rd_b), .dout(dout_b), .data_count_r(cnt_b),
    .overflow(ovf_b), .frame_count(fc_b), .dbg_state(st_b)
  );

  // Scoreboard and reference model state.
  logic [16:0] exp_a[$], exp_b[$], got_a[$];
  logic [7:0]  lb[$];
  int  m_line[2], m_frames[2];
  bit  m_cap[2];
  bit  drain_a = 1'b0, drain_b = 1'b0, seen_drop_b = 1'b0;
  int  n_vec = 0, n_err = 0, n_extra = 0;
  int  n_rd_a = 0, n_sof_a = 0, n_rd_b = 0, n_sof_b = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Readers: pop when the visible fill count is non-zero, check dout half a cycle later.
  initial begin
    forever begin
      @(negedge clk_r);
      if (rd_a) begin
        n_rd_a++;
        if (dout_a[16]) n_sof_a++;
        got_a.push_back(dout_a);
        if (exp_a.size() == 0) n_extra++;
        else check_eq("a_word", {15'd0, dout_a}, {15'd0, exp_a.pop_front()});
      end
      rd_a = drain_a && rst_n && (cnt_a != 10'd0);
    end
  end

  initial begin
    forever begin
      @(negedge clk_r);
      if (rd_b) begin
        n_rd_b++;
        if (dout_b[16]) n_sof_b++;
        if (exp_b.size() == 0) n_extra++;
        else check_eq("b_word", {15'd0, dout_b}, {15'd0, exp_b.pop_front()});
      end
      rd_b = drain_b && rst_n && (cnt_b != 10'd0);
    end
  end

  initial begin
    forever begin
      @(negedge clk_w);
      if (st_b == 2'd3) seen_drop_b = 1'b1;
    end
  end

  task automatic strobe(input logic v, input logic h, input logic [7:0] d);
    @(posedge clk_w); #1;
    vs = v; hr = h; dat = d; pclk_en = 1'b1;
    @(posedge clk_w); #1;
    pclk_en = 1'b0;
    repeat ($urandom_range(0, 1)) @(posedge clk_w);
  endtask

  task automatic start_frame(input int s);
    sel = s;
    strobe(1'b1, 1'b0, 8'h00);
    strobe(1'b1, 1'b0, 8'h00);
    strobe(1'b0, 1'b0, 8'h00);
    m_line[s] = 0;
    m_cap[s]  = 1'b1;
  endtask

  task automatic end_by_vsync(input int s);
    sel = s;
    strobe(1'b1, 1'b0, 8'h00);
    if (m_cap[s]) begin
      m_frames[s]++;
      m_cap[s] = 1'b0;
    end
  endtask

  function automatic void fill_line(input int nbytes);
    lb.delete();
    for (int i = 0; i < nbytes; i++) lb.push_back(8'($urandom_range(0, 255)));
  endfunction

  // Model: pair bytes, keep at most a line's worth, tag pixel (0,0); a stalled
  // reader with a full FIFO aborts the rest of the frame.
  task automatic send_line(input int s, input bit close);
    int lp, fl, npix;
    logic [16:0] w;
    lp = (s == 0) ? LP_A : LP_B;
    fl = (s == 0) ? FL_A : FL_B;
    npix = lb.size() / 2;
    if (npix > lp) npix = lp;
    for (int k = 0; k < npix; k++) begin
      if (m_cap[s]) begin
        w = {(m_line[s] == 0 && k == 0), lb[2*k], lb[2*k+1]};
        if (s == 0) exp_a.push_back(w);
        else if (!drain_b && exp_b.size() == DEPTH) m_cap[s] = 1'b0;
        else exp_b.push_back(w);
      end
    end
    sel = s;
    for (int i = 0; i < lb.size(); i++) strobe(1'b0, 1'b1, lb[i]);
    if (close) begin
      strobe(1'b0, 1'b0, 8'h00);
      if (m_cap[s]) begin
        m_line[s]++;
        if (m_line[s] == fl) begin
          m_frames[s]++;
          m_cap[s] = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_drain(input int s);
    int t;
    t = 0;
    while (((s == 0) ? exp_a.size() : exp_b.size()) != 0 && t < 20000) begin
      @(posedge clk_w);
      t++;
    end
    check_eq("drain_timeout", {31'd0, (t < 20000)}, 32'd1);
    repeat (20) @(posedge clk_w);
  endtask

  task automatic begin_scenario();
    n_rd_a = 0; n_sof_a = 0; n_rd_b = 0; n_sof_b = 0;
    got_a.delete();
  endtask

  initial begin
    m_line = '{0, 0}; m_frames = '{0, 0}; m_cap = '{1'b0, 1'b0};
    rst_n = 1'b0;
    repeat (5) @(posedge clk_w); #1;
    check_eq("rst_state", {30'd0, st_a}, 32'd0);
    check_eq("rst_ovf", {31'd0, ovf_a}, 32'd0);
    check_eq("rst_fc", {24'd0, fc_a}, 32'd0);
    check_eq("rst_cnt", {22'd0, cnt_a}, 32'd0);
    check_eq("rst_dout", {15'd0, dout_a}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk_w);

    // Clean 4x2 frame with reader draining.
    begin_scenario();
    drain_a = 1'b1;
    start_frame(0);
    fill_line(8); lb[2] = 8'hF8; lb[3] = 8'h1F;
    send_line(0, 1'b1);
    fill_line(8); send_line(0, 1'b1);
    wait_drain(0);
    check_eq("clean_words", n_rd_a, 32'd8);
    check_eq("clean_sof", n_sof_a, 32'd1);
    check_eq("clean_first_sof", {31'd0, got_a[0][16]}, 32'd1);
    check_eq("clean_px1", {15'd0, got_a[1]}, 32'h0F81F);
    check_eq("clean_fc", {24'd0, fc_a}, m_frames[0]);
    check_eq("clean_ovf", {31'd0, ovf_a}, 32'd0);

    // Odd byte count at end of line, next line must restart at phase 0.
    begin_scenario();
    start_frame(0);
    fill_line(7); send_line(0, 1'b1);
    fill_line(8); send_line(0, 1'b1);
    wait_drain(0);
    check_eq("odd_words", n_rd_a, 32'd7);
    check_eq("odd_fc", {24'd0, fc_a}, m_frames[0]);

    // Over-long line: clipped to a line's worth, line count steps by one.
    begin_scenario();
    start_frame(0);
    fill_line(2 * (LP_A + 2)); send_line(0, 1'b1);
    repeat (4) @(posedge clk_w);
    check_eq("long_mid_state", {30'd0, st_a}, 32'd2);
    check_eq("long_mid_fc", {24'd0, fc_a}, m_frames[0]);
    fill_line(8); send_line(0, 1'b1);
    wait_drain(0);
    check_eq("long_words", n_rd_a, 32'd8);
    check_eq("long_fc", {24'd0, fc_a}, m_frames[0]);
    check_eq("long_state", {30'd0, st_a}, 32'd0);

    // Short frame closed by vsync after line 0, then a full frame.
    begin_scenario();
    start_frame(0);
    fill_line(8); send_line(0, 1'b1);
    end_by_vsync(0);
    repeat (4) @(posedge clk_w);
    check_eq("short_fc", {24'd0, fc_a}, m_frames[0]);
    check_eq("short_state", {30'd0, st_a}, 32'd1);
    start_frame(0);
    fill_line(8); send_line(0, 1'b1);
    fill_line(8); send_line(0, 1'b1);
    wait_drain(0);
    check_eq("short_words", n_rd_a, 32'd12);
    check_eq("short_next_sof", {31'd0, got_a[4][16]}, 32'd1);
    check_eq("short_fc2", {24'd0, fc_a}, m_frames[0]);

    // Reset during line 1 with the reader stalled.
    drain_a = 1'b0;
    repeat (10) @(posedge clk_w);
    begin_scenario();
    start_frame(0);
    fill_line(8); send_line(0, 1'b1);
    fill_line(5); send_line(0, 1'b0);
    repeat (10) @(posedge clk_r);
    check_eq("pre_rst_cnt", {22'd0, cnt_a}, exp_a.size());
    rst_n = 1'b0;
    repeat (3) @(posedge clk_w); #1;
    exp_a.delete();
    m_line = '{0, 0}; m_frames = '{0, 0}; m_cap = '{1'b0, 1'b0};
    check_eq("mid_rst_cnt", {22'd0, cnt_a}, 32'd0);
    check_eq("mid_rst_fc", {24'd0, fc_a}, 32'd0);
    check_eq("mid_rst_state", {30'd0, st_a}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk_w);
    drain_a = 1'b1;
    start_frame(0);
    fill_line(8); send_line(0, 1'b1);
    fill_line(8); send_line(0, 1'b1);
    wait_drain(0);
    check_eq("rst_frame_words", n_rd_a, 32'd8);
    check_eq("rst_frame_sof", n_sof_a, 32'd1);
    check_eq("rst_frame_fc", {24'd0, fc_a}, m_frames[0]);

    // Overflow: stalled reader, 1100-pixel frame.
    begin_scenario();
    drain_b = 1'b0;
    seen_drop_b = 1'b0;
    start_frame(1);
    fill_line(2 * LP_B); send_line(1, 1'b1);
    repeat (5) @(posedge clk_w); #1;
    check_eq("ovf_flag", {31'd0, ovf_b}, 32'd1);
    check_eq("ovf_fc", {24'd0, fc_b}, m_frames[1]);
    check_eq("ovf_drop_seen", {31'd0, seen_drop_b}, 32'd1);
    check_eq("ovf_state", {30'd0, st_b}, 32'd0);
    drain_b = 1'b1;
    wait_drain(1);
    check_eq("ovf_words", n_rd_b, DEPTH);

    begin_scenario();
    start_frame(1);
    fill_line(2 * LP_B); send_line(1, 1'b1);
    wait_drain(1);
    check_eq("after_ovf_words", n_rd_b, LP_B);
    check_eq("after_ovf_sof", n_sof_b, 32'd1);
    check_eq("after_ovf_fc", {24'd0, fc_b}, m_frames[1]);
    check_eq("after_ovf_sticky", {31'd0, ovf_b}, 32'd1);

    repeat (50) @(posedge clk_w);
    check_eq("extra_words", n_extra, 32'd0);
    check_eq("left_a", exp_a.size(), 32'd0);
    check_eq("left_b", exp_b.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
